// File: rtl/dvp_frame_source.sv
`default_nettype none
// ============================================================================
// dvp_frame_source : OV7670-style DVP emitter (stream, colour bars or ramp)
// Revision 1.0
// ============================================================================
module dvp_frame_source #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10,
  parameter int PCLK_HALF   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        cmos_pclk,
  output logic        cmos_href,
  output logic        cmos_vsync,
  output logic [7:0]  cmos_db,
  output logic        frame_done,
  output logic        underrun,
  output logic        busy
);

  localparam int PH_N       = 2 * PCLK_HALF;
  localparam int LINE_SLOTS = 2 * H_ACTIVE + H_BLANK;
  localparam int ACT_SLOTS  = 2 * H_ACTIVE;
  localparam int BAR_W      = H_ACTIVE / 8;
  localparam int MAX_A      = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int MAX_B      = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int MAX_LINES  = (MAX_A > MAX_B) ? MAX_A : MAX_B;

  localparam int PH_W   = $clog2(PH_N);
  localparam int SLOT_W = $clog2(LINE_SLOTS);
  localparam int LINE_W = $clog2(MAX_LINES + 1);
  localparam int BAR_CW = $clog2(BAR_W + 1);

  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(PH_N - 1);
  localparam logic [PH_W-1:0]   PH_HALF   = PH_W'(PCLK_HALF);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(LINE_SLOTS - 1);
  localparam logic [SLOT_W-1:0] SLOT_ACT  = SLOT_W'(ACT_SLOTS);
  localparam logic [LINE_W-1:0] VF_LAST   = LINE_W'(V_FRONT - 1);
  localparam logic [BAR_CW-1:0] BAR_LAST  = BAR_CW'(BAR_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBACK  = 3'd2,
    ACTIVE = 3'd3,
    VFRONT = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic [PH_W-1:0]   ph, ph_nx;
  logic [SLOT_W-1:0] slot, slot_nx;
  logic [LINE_W-1:0] line, line_nx;
  logic [1:0]        mode_q, mode_nx;
  logic [15:0]       pix, pix_nx;
  logic [BAR_CW-1:0] bar_cnt, bar_cnt_nx;
  logic [2:0]        bar_idx, bar_idx_nx;
  logic              fetch, fetch_nx;
  logic              pclk_nx, href_nx, vsync_nx, s_ready_nx;
  logic              frame_done_nx, underrun_nx, busy_nx;
  logic [7:0]        db_nx;
  logic              stream;
  logic [15:0]       pix_sel;

  function automatic logic [LINE_W-1:0] lines_last(input state_t s);
    case (s)
      VSYNC:   lines_last = LINE_W'(VSYNC_LINES - 1);
      VBACK:   lines_last = LINE_W'(V_BACK - 1);
      ACTIVE:  lines_last = LINE_W'(V_ACTIVE - 1);
      default: lines_last = VF_LAST;
    endcase
  endfunction

  function automatic state_t state_after(input state_t s);
    case (s)
      VSYNC:   state_after = VBACK;
      VBACK:   state_after = ACTIVE;
      ACTIVE:  state_after = VFRONT;
      VFRONT:  state_after = VFRONT;
      default: state_after = IDLE;
    endcase
  endfunction

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = 16'hFFFF;
      3'd1:    bar_colour = 16'hFFE0;
      3'd2:    bar_colour = 16'h07FF;
      3'd3:    bar_colour = 16'h07E0;
      3'd4:    bar_colour = 16'hF81F;
      3'd5:    bar_colour = 16'hF800;
      3'd6:    bar_colour = 16'h001F;
      default: bar_colour = 16'h0000;
    endcase
  endfunction

  assign stream = (mode_q == 2'd0) || (mode_q == 2'd3);

  // Column index is the slot pair index; it is only consulted on even active slots.
  always_comb begin
    case (mode_q)
      2'd1:    pix_sel = bar_colour(bar_idx);
      2'd2:    pix_sel = {8'(line), 8'(slot >> 1)};
      default: pix_sel = s_valid ? s_data : 16'h0000;
    endcase
  end

  always_comb begin
    state_nx      = state;
    ph_nx         = ph;
    slot_nx       = slot;
    line_nx       = line;
    mode_nx       = mode_q;
    pix_nx        = pix;
    bar_cnt_nx    = bar_cnt;
    bar_idx_nx    = bar_idx;
    pclk_nx       = cmos_pclk;
    href_nx       = cmos_href;
    vsync_nx      = cmos_vsync;
    db_nx         = cmos_db;
    fetch_nx      = 1'b0;
    s_ready_nx    = 1'b0;
    frame_done_nx = 1'b0;
    underrun_nx   = underrun;

    if (state == IDLE || frame_done) begin
      // Frame boundary: either start a fresh frame at ph 0 or park in IDLE.
      ph_nx      = '0;
      slot_nx    = '0;
      line_nx    = '0;
      bar_cnt_nx = '0;
      bar_idx_nx = '0;
      pclk_nx    = 1'b0;
      href_nx    = 1'b0;
      db_nx      = '0;
      if (en) begin
        state_nx = VSYNC;
        vsync_nx = 1'b1;
        mode_nx  = mode;
      end else begin
        state_nx = IDLE;
        vsync_nx = 1'b0;
      end
    end else begin
      if (ph == PH_LAST) begin
        ph_nx = '0;
        if (slot == SLOT_LAST) begin
          slot_nx = '0;
          if (line == lines_last(state)) begin
            line_nx  = '0;
            state_nx = state_after(state);
          end else begin
            line_nx = line + LINE_W'(1);
          end
        end else begin
          slot_nx = slot + SLOT_W'(1);
        end
      end else begin
        ph_nx = ph + PH_W'(1);
      end

      pclk_nx = (ph_nx >= PH_HALF);

      if (ph_nx == '0) begin
        vsync_nx   = (state_nx == VSYNC);
        href_nx    = (state_nx == ACTIVE) && (slot_nx < SLOT_ACT);
        fetch_nx   = href_nx && !slot_nx[0];
        s_ready_nx = href_nx && !slot_nx[0] && stream;
        if (!href_nx)
          db_nx = '0;
        else if (slot_nx[0])
          db_nx = pix[7:0];
        if (slot_nx == '0) begin
          bar_cnt_nx = '0;
          bar_idx_nx = '0;
        end
      end

      frame_done_nx = (state_nx == VFRONT) && (line_nx == VF_LAST) &&
                      (slot_nx == SLOT_LAST) && (ph_nx == PH_LAST);

      // The pixel is taken at the end of the fetch cycle, so the high byte
      // reaches db one clk after the slot starts, well before pclk rises.
      if (fetch) begin
        pix_nx = pix_sel;
        db_nx  = pix_sel[15:8];
        if (stream && !s_valid)
          underrun_nx = 1'b1;
        if (bar_cnt == BAR_LAST) begin
          bar_cnt_nx = '0;
          bar_idx_nx = bar_idx + 3'd1;
        end else begin
          bar_cnt_nx = bar_cnt + BAR_CW'(1);
        end
      end
    end

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ph         <= '0;
      slot       <= '0;
      line       <= '0;
      mode_q     <= '0;
      pix        <= '0;
      bar_cnt    <= '0;
      bar_idx    <= '0;
      fetch      <= 1'b0;
      cmos_pclk  <= 1'b0;
      cmos_href  <= 1'b0;
      cmos_vsync <= 1'b0;
      cmos_db    <= '0;
      s_ready    <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      ph         <= ph_nx;
      slot       <= slot_nx;
      line       <= line_nx;
      mode_q     <= mode_nx;
      pix        <= pix_nx;
      bar_cnt    <= bar_cnt_nx;
      bar_idx    <= bar_idx_nx;
      fetch      <= fetch_nx;
      cmos_pclk  <= pclk_nx;
      cmos_href  <= href_nx;
      cmos_vsync <= vsync_nx;
      cmos_db    <= db_nx;
      s_ready    <= s_ready_nx;
      frame_done <= frame_done_nx;
      underrun   <= underrun_nx;
      busy       <= busy_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dvp_frame_source.sv
`default_nettype none
// ============================================================================
// tb_dvp_frame_source : directed bench with byte scoreboard for dvp_frame_source
// Revision 1.0
// ============================================================================
module tb_dvp_frame_source;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] s_data = 16'h1234;
  logic        s_valid = 1'b1;
  logic        s_ready;
  logic        cmos_pclk, cmos_href, cmos_vsync;
  logic [7:0]  cmos_db;
  logic        frame_done, underrun, busy;

  int          n_assert = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          rdy_total = 0;
  int          rdy_base = 0;
  int          drop_at = -1;
  bit          pend_inc = 1'b0;
  logic        prev_pclk = 1'b0;
  logic [7:0]  sb_q[$];
  logic [15:0] model_next = 16'h1234;

  always #5 clk = ~clk;

  dvp_frame_source #(
    .H_ACTIVE(8), .V_ACTIVE(2), .H_BLANK(4), .VSYNC_LINES(1),
    .V_BACK(1), .V_FRONT(1), .PCLK_HALF(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cmos_pclk(cmos_pclk), .cmos_href(cmos_href), .cmos_vsync(cmos_vsync),
    .cmos_db(cmos_db), .frame_done(frame_done), .underrun(underrun), .busy(busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic wait_to(input int c);
    step(c - cyc);
  endtask

  task automatic push_pix(input logic [15:0] p);
    sb_q.push_back(p[15:8]);
    sb_q.push_back(p[7:0]);
  endtask

  task automatic push_ramp();
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < 8; c++)
        push_pix({8'(l), 8'(c)});
  endtask

  task automatic push_bars();
    logic [15:0] bars [8];
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < 8; c++)
        push_pix(bars[c]);
  endtask

  // A dropped pixel is sent as zero and does not consume a source word.
  task automatic push_stream(input int drop_idx);
    for (int i = 0; i < 16; i++) begin
      if (i == drop_idx) begin
        push_pix(16'h0000);
      end else begin
        push_pix(model_next);
        model_next = model_next + 16'd1;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pclk"}, 16'(cmos_pclk), 16'd0);
    chk({tag, "_href"}, 16'(cmos_href), 16'd0);
    chk({tag, "_vsync"}, 16'(cmos_vsync), 16'd0);
    chk({tag, "_db"}, 16'(cmos_db), 16'd0);
    chk({tag, "_s_ready"}, 16'(s_ready), 16'd0);
    chk({tag, "_frame_done"}, 16'(frame_done), 16'd0);
    chk({tag, "_underrun"}, 16'(underrun), 16'd0);
    chk({tag, "_busy"}, 16'(busy), 16'd0);
  endtask

  task automatic chk_frame_end(input string tag, input int exp_rdy, input logic exp_udr);
    chk({tag, "_frame_done"}, 16'(frame_done), 16'd1);
    chk({tag, "_busy"}, 16'(busy), 16'd1);
    chk({tag, "_sb_left"}, 16'(sb_q.size()), 16'd0);
    chk({tag, "_s_ready_count"}, 16'(rdy_total - rdy_base), 16'(exp_rdy));
    chk({tag, "_underrun"}, 16'(underrun), 16'(exp_udr));
    rdy_base = rdy_total;
  endtask

  // Monitor: upstream source model plus byte scoreboard on every pclk rise.
  always begin : monitor
    logic [7:0] exp_b;
    @(posedge clk);
    #1;
    if (pend_inc) begin
      s_data   = s_data + 16'd1;
      pend_inc = 1'b0;
    end
    if (s_ready === 1'b1) begin
      chk("s_ready_in_href", 16'(cmos_href), 16'd1);
      s_valid  = (rdy_total != drop_at);
      pend_inc = s_valid;
      rdy_total++;
    end
    if (prev_pclk === 1'b0 && cmos_pclk === 1'b1) begin
      if (cmos_href === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_assert++;
          n_fail++;
          $error("FAIL db_unexpected: observed %h expected no byte (cycle %0d)", cmos_db, cyc);
        end else begin
          exp_b = sb_q.pop_front();
          chk("db_byte", 16'(cmos_db), 16'(exp_b));
        end
      end else begin
        chk("db_blank", 16'(cmos_db), 16'd0);
      end
    end
    prev_pclk = cmos_pclk;
  end

  initial begin
    step(3);
    chk_all_zero("reset");
    rst = 1'b0;
    step(2);
    chk_all_zero("idle");

    // Frame 1: coordinate ramp; vsync at cycle 1, frame ends at cycle 400.
    cyc  = 0;
    push_ramp();
    mode = 2'd2;
    en   = 1'b1;
    step(1);
    chk("f1_vsync_rise", 16'(cmos_vsync), 16'd1);
    chk("f1_busy", 16'(busy), 16'd1);
    chk("f1_pclk_ph0", 16'(cmos_pclk), 16'd0);
    wait_to(3);
    chk("f1_pclk_ph2", 16'(cmos_pclk), 16'd1);
    wait_to(80);
    chk("f1_vsync_last", 16'(cmos_vsync), 16'd1);
    wait_to(81);
    chk("f1_vsync_fall", 16'(cmos_vsync), 16'd0);
    wait_to(160);
    chk("f1_href_before", 16'(cmos_href), 16'd0);
    wait_to(161);
    chk("f1_href_rise", 16'(cmos_href), 16'd1);
    mode = 2'd1;
    wait_to(399);
    chk("f1_frame_done_early", 16'(frame_done), 16'd0);
    wait_to(400);
    chk_frame_end("f1", 0, 1'b0);

    // Frame 2: colour bars, started back to back.
    push_bars();
    wait_to(401);
    chk("f2_vsync_no_gap", 16'(cmos_vsync), 16'd1);
    chk("f2_frame_done_pulse", 16'(frame_done), 16'd0);
    wait_to(624);
    chk("f2_href_last_act", 16'(cmos_href), 16'd1);
    wait_to(625);
    chk("f2_href_blank_start", 16'(cmos_href), 16'd0);
    chk("f2_db_blank", 16'(cmos_db), 16'd0);
    wait_to(640);
    chk("f2_href_blank_end", 16'(cmos_href), 16'd0);
    wait_to(641);
    chk("f2_href_line2", 16'(cmos_href), 16'd1);
    mode = 2'd0;
    wait_to(800);
    chk_frame_end("f2", 0, 1'b0);

    // Frame 3: stream, every pixel valid.
    push_stream(-1);
    wait_to(1200);
    chk_frame_end("f3", 16, 1'b0);

    // Frame 4: stream with pixel 3 missing.
    drop_at = rdy_total + 3;
    push_stream(3);
    wait_to(1600);
    chk_frame_end("f4", 16, 1'b1);

    // Frame 5: stream again; en dropped mid-ACTIVE.
    push_stream(-1);
    wait_to(1771);
    en = 1'b0;
    wait_to(1800);
    chk("f5_underrun_sticky", 16'(underrun), 16'd1);
    chk("f5_busy_after_en_low", 16'(busy), 16'd1);
    wait_to(2000);
    chk_frame_end("f5", 16, 1'b1);
    wait_to(2001);
    chk("idle_busy", 16'(busy), 16'd0);
    chk("idle_pclk", 16'(cmos_pclk), 16'd0);
    chk("idle_vsync", 16'(cmos_vsync), 16'd0);
    chk("idle_frame_done", 16'(frame_done), 16'd0);
    wait_to(2010);
    chk("idle_hold_busy", 16'(busy), 16'd0);
    chk("idle_underrun_sticky", 16'(underrun), 16'd1);

    // Frame 6: ramp interrupted by reset mid-line.
    push_ramp();
    mode = 2'd2;
    en   = 1'b1;
    step(1);
    chk("f6_vsync_rise", 16'(cmos_vsync), 16'd1);
    wait_to(2181);
    chk("f6_href_mid", 16'(cmos_href), 16'd1);
    rst = 1'b1;
    step(1);
    chk_all_zero("midreset");
    sb_q.delete();
    push_ramp();
    rst = 1'b0;
    step(1);
    chk("f7_vsync_rise", 16'(cmos_vsync), 16'd1);
    chk("f7_busy", 16'(busy), 16'd1);
    rdy_base = rdy_total;
    wait_to(2262);
    chk("f7_vsync_last", 16'(cmos_vsync), 16'd1);
    wait_to(2263);
    chk("f7_vsync_fall", 16'(cmos_vsync), 16'd0);
    en = 1'b0;
    wait_to(2582);
    chk_frame_end("f7", 0, 1'b0);
    wait_to(2583);
    chk("f7_idle_busy", 16'(busy), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
